// File: rtl/f_fetch_stage_if.sv
// Instruction-memory bus between the F stage (master) and the instruction memory (slave).
// The memory returns i_inst_rdata combinationally from i_inst_addr.
interface f_fetch_stage_if;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;

  modport master (output i_inst_addr, input i_inst_rdata);
  modport slave  (input i_inst_addr, output i_inst_rdata);
endinterface

// File: rtl/f_fetch_stage.sv
// F stage of the 5-stage MIPS pipeline: PC register, next-PC selection, AdEL fetch check.
// Optional feature macro F_FETCH_PERF_EN adds fetch_cnt/stall_cnt performance counters.
module f_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY  = 32'h0000_4180,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IMEM_LIMIT = 32'h0000_6ffc
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Req,
  input  logic              en,
  input  logic              branch_taken_D,
  input  logic [31:0]       branch_target_D,
  input  logic              is_branch_D,
  input  logic              eret_D,
  input  logic [31:0]       EPC,
  f_fetch_stage_if.master   imem,
  output logic [31:0]       Instr_F,
  output logic [31:0]       PC_F,
  output logic [4:0]        ExcCode_F,
  output logic              bd_F
`ifdef F_FETCH_PERF_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic        adel;

  // Req outranks a stall so an exception is never lost while the pipe is frozen.
  always_comb begin
    pc_next = pc_q + 32'd4;
    if (Req)                 pc_next = EXC_ENTRY;
    else if (!en)            pc_next = pc_q;
    else if (eret_D)         pc_next = EPC;
    else if (branch_taken_D) pc_next = branch_target_D;
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_next;
  end

  assign adel = (pc_q[1:0] != 2'b00) | (pc_q < IMEM_BASE) | (pc_q > IMEM_LIMIT);

  assign imem.i_inst_addr = pc_q;
  assign PC_F             = pc_q;

  // An eret in D squashes the slot instruction, hiding any fetch fault it would raise.
  always_comb begin
    Instr_F   = imem.i_inst_rdata;
    ExcCode_F = 5'd0;
    bd_F      = is_branch_D & ~eret_D;
    if (eret_D) begin
      Instr_F   = 32'd0;
      ExcCode_F = 5'd0;
    end else if (adel) begin
      Instr_F   = 32'd0;
      ExcCode_F = EXC_ADEL;
    end
  end

`ifdef F_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else if (!Req) begin
      if (en && !adel && !eret_D) fetch_cnt <= fetch_cnt + 32'd1;
      if (!en)                    stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_f_fetch_stage.sv
// Bench for f_fetch_stage: directed vectors, a rule-level reference model checked every cycle,
// and literal expectations for the documented scenarios (plus counters when F_FETCH_PERF_EN).
module tb_f_fetch_stage;
  logic        clk = 1'b0;
  logic        reset, Req, en, branch_taken_D, is_branch_D, eret_D;
  logic [31:0] branch_target_D, EPC;
  logic [31:0] Instr_F, PC_F;
  logic [4:0]  ExcCode_F;
  logic        bd_F;
`ifdef F_FETCH_PERF_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  f_fetch_stage_if bus ();

  f_fetch_stage dut (
    .clk(clk), .reset(reset), .Req(Req), .en(en),
    .branch_taken_D(branch_taken_D), .branch_target_D(branch_target_D),
    .is_branch_D(is_branch_D), .eret_D(eret_D), .EPC(EPC),
    .imem(bus.master),
    .Instr_F(Instr_F), .PC_F(PC_F), .ExcCode_F(ExcCode_F), .bd_F(bd_F)
`ifdef F_FETCH_PERF_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h3401_0001;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign bus.i_inst_rdata = mem_word(bus.i_inst_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the architectural PC plus output rules applied directly.
  logic [31:0] m_pc;
  logic        m_valid = 1'b0;
  logic [31:0] m_fetch, m_stall;

  function automatic logic m_fault(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6ffc);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_pc    <= 32'h3000;
      m_valid <= 1'b1;
      m_fetch <= 0;
      m_stall <= 0;
    end else if (m_valid) begin
      if (!Req && en && !m_fault(m_pc) && !eret_D) m_fetch <= m_fetch + 1;
      if (!Req && !en) m_stall <= m_stall + 1;
      if (Req)                 m_pc <= 32'h4180;
      else if (!en)            m_pc <= m_pc;
      else if (eret_D)         m_pc <= EPC;
      else if (branch_taken_D) m_pc <= branch_target_D;
      else                     m_pc <= m_pc + 4;
    end
  end

  always @(negedge clk) begin
    if (m_valid && !reset) begin
      logic [31:0] e_instr;
      logic [4:0]  e_exc;
      if (eret_D)              begin e_instr = 0; e_exc = 0; end
      else if (m_fault(m_pc))  begin e_instr = 0; e_exc = 4; end
      else                     begin e_instr = mem_word(m_pc); e_exc = 0; end
      check("model_pc",    PC_F, m_pc);
      check("model_addr",  bus.i_inst_addr, m_pc);
      check("model_instr", Instr_F, e_instr);
      check("model_exc",   {27'd0, ExcCode_F}, {27'd0, e_exc});
      check("model_bd",    {31'd0, bd_F}, {31'd0, is_branch_D && !eret_D});
`ifdef F_FETCH_PERF_EN
      check("model_fetch_cnt", fetch_cnt, m_fetch);
      check("model_stall_cnt", stall_cnt, m_stall);
`endif
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    Req = 0; en = 1; branch_taken_D = 0; is_branch_D = 0; eret_D = 0;
    branch_target_D = 0; EPC = 0;
  endtask

  task automatic branch_to(input logic [31:0] t);
    is_branch_D = 1; branch_taken_D = 1; branch_target_D = t;
    step();
    is_branch_D = 0; branch_taken_D = 0;
    #1;
  endtask

  initial begin
    idle();
    reset = 1;
    step();
    reset = 0;
    #1;
    // Reset and sequential fetch
    check("reset_pc",    PC_F, 32'h3000);
    check("reset_instr", Instr_F, 32'h3401_0001);
    check("reset_exc",   {27'd0, ExcCode_F}, 32'd0);
    check("reset_bd",    {31'd0, bd_F}, 32'd0);
    step();
    check("seq_pc", PC_F, 32'h3004);
    step();
    check("seq_pc2", PC_F, 32'h3008);
    // Stall holds, then advances
    en = 0;
    step(3);
    check("stall_hold", PC_F, 32'h3008);
    en = 1;
    step();
    check("stall_release", PC_F, 32'h300c);
    step();
    // Taken branch: delay slot marked, redirect next edge
    is_branch_D = 1; branch_taken_D = 1; branch_target_D = 32'h3100;
    #1;
    check("br_slot_bd", {31'd0, bd_F}, 32'd1);
    check("br_slot_pc", PC_F, 32'h3010);
    step();
    is_branch_D = 0; branch_taken_D = 0;
    #1;
    check("br_target_pc", PC_F, 32'h3100);
    check("br_target_bd", {31'd0, bd_F}, 32'd0);
    // Not-taken branch still marks bd
    is_branch_D = 1;
    #1;
    check("nt_bd", {31'd0, bd_F}, 32'd1);
    step();
    is_branch_D = 0;
    #1;
    check("nt_pc", PC_F, 32'h3104);
    // Branch ignored while stalled, applied on first enabled edge
    en = 0; branch_taken_D = 1; branch_target_D = 32'h3200;
    step();
    check("br_stall_hold", PC_F, 32'h3104);
    en = 1;
    step();
    branch_taken_D = 0;
    #1;
    check("br_after_stall", PC_F, 32'h3200);
    // Fetch faults
    branch_to(32'h3102);
    check("adel_misalign_pc",    PC_F, 32'h3102);
    check("adel_misalign_exc",   {27'd0, ExcCode_F}, 32'd4);
    check("adel_misalign_instr", Instr_F, 32'd0);
    check("adel_addr",           bus.i_inst_addr, 32'h3102);
    branch_to(32'h7000);
    check("adel_high_exc", {27'd0, ExcCode_F}, 32'd4);
    branch_to(32'h6ffc);
    check("limit_ok_exc",   {27'd0, ExcCode_F}, 32'd0);
    check("limit_ok_instr", Instr_F, 32'h6ffc_9003);
    branch_to(32'h2ffc);
    check("adel_low_exc", {27'd0, ExcCode_F}, 32'd4);
    // Faulting slot still carries bd; eret squash beats adel
    is_branch_D = 1;
    #1;
    check("adel_slot_bd", {31'd0, bd_F}, 32'd1);
    is_branch_D = 0; eret_D = 1; en = 0;
    #1;
    check("squash_over_adel", {27'd0, ExcCode_F}, 32'd0);
    eret_D = 0; en = 1;
    // PC wrap
    branch_to(32'hffff_fffc);
    step();
    check("wrap_pc",  PC_F, 32'h0);
    check("wrap_exc", {27'd0, ExcCode_F}, 32'd4);
    // Req beats stall and eret
    Req = 1; eret_D = 1; en = 0; EPC = 32'h3050;
    step();
    Req = 0;
    check("req_pc", PC_F, 32'h4180);
    // eret: squashed slot, return to EPC
    eret_D = 1; EPC = 32'h3020; en = 1; is_branch_D = 1;
    #1;
    check("eret_instr", Instr_F, 32'd0);
    check("eret_bd",    {31'd0, bd_F}, 32'd0);
    check("eret_exc",   {27'd0, ExcCode_F}, 32'd0);
    step();
    eret_D = 0; is_branch_D = 0;
    #1;
    check("eret_pc", PC_F, 32'h3020);
    // Reset overrides Req
    reset = 1; Req = 1;
    step();
    reset = 0; Req = 0;
    #1;
    check("reset_over_req", PC_F, 32'h3000);
`ifdef F_FETCH_PERF_EN
    check("perf_reset_fetch", fetch_cnt, 32'd0);
    check("perf_reset_stall", stall_cnt, 32'd0);
    step(5);
    en = 0;
    step(2);
    en = 1;
    check("perf_fetch", fetch_cnt, 32'd5);
    check("perf_stall", stall_cnt, 32'd2);
`else
    step(2);
    check("post_reset_seq", PC_F, 32'h3008);
`endif
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end
endmodule
